mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Sequences and shares the single-port synchronous instruction/data memory of the multi-cycle CPU between three requesters: instruction fetch, data access (lw/sw), and the boot/debug loader. It accepts one transaction at a time, drives the memory port, counts the fixed read latency and returns a per-requester completion pulse. It sits between the control unit/datapath and the memory macro, replacing direct MemRd/MemWr wiring.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, memory read latency in cycles after the mem_en cycle; legal range 1..7
- STARVE_MAX, 4, consecutive data grants allowed while fetch is pending; legal range 1..15

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch read request; level, held until if_done
- if_addr  in  ADDR_W  fetch address
- dm_req, dm_we  in  1  data request; 1 = write
- dm_addr  in  ADDR_W ; dm_wdata  in  DATA_W
- ld_req, ld_we  in  1  loader request; 1 = write
- ld_addr  in  ADDR_W ; ld_wdata  in  DATA_W
- gnt  out  3  one-cycle grant pulse; bit 0 fetch, 1 data, 2 loader
- done  out  3  one-cycle completion pulse, same bit order
- rdata  out  DATA_W  read data, valid only while the owning done bit is high
- busy  out  1  high in every state except IDLE
- mem_en, mem_we  out  1  memory strobe / write enable
- mem_addr  out  ADDR_W ; mem_wdata  out  DATA_W
- mem_rdata  in  DATA_W  valid MEM_LAT cycles after the mem_en cycle

## Operation
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE: if any req is high, pick a winner, latch owner, we, addr, wdata; go to ACCESS. Fetch always has we = 0.
- Priority: loader > data > fetch, except when starve_cnt == STARVE_MAX and if_req is high, where fetch beats data (loader still wins).
- starve_cnt: +1 on each data grant while if_req is high (saturates at STARVE_MAX); cleared on a fetch grant; unchanged otherwise.
- ACCESS (1 cycle): gnt[owner] = 1, mem_en = 1, mem_we = latched we, mem_addr/mem_wdata = latched values. Write goes to RESP; read goes to WAIT when MEM_LAT > 1, otherwise to RESP.
- WAIT: 3-bit counter; stays MEM_LAT-1 cycles, then RESP.
- RESP (1 cycle): done[owner] = 1. For a read, rdata = mem_rdata (combinational pass-through). Go to IDLE.
- IDLE is always visited between transactions.
- The requester drops req in the cycle after its done. A req still high in IDLE is a new request.
- A req dropped mid-transaction is ignored; the transaction completes and done still pulses.
- Request signals are sampled only in IDLE.
- Outside ACCESS: mem_en = mem_we = 0, and mem_addr/mem_wdata hold their latched values.
- gnt, done, mem_en, mem_we and busy decode from state only.
- Reset values: state IDLE, owner 0, starve_cnt 0, latched addr/wdata/we 0, all outputs 0.
- Reset mid-transaction aborts it with no done pulse. If reset is asserted during ACCESS, mem_en falls immediately.

## Timing
- Read: req high at cycle t -> gnt and mem_en at t+1 -> done and rdata at t+1+MEM_LAT. Throughput is one read per MEM_LAT+2 cycles.
- Write: req at t -> gnt, mem_en, mem_we at t+1 -> done at t+2. Throughput is one write per 3 cycles.
- Simultaneous requests are resolved in the single IDLE cycle. Losers keep req high and are re-arbitrated in the next IDLE.

## Structure
- Shared package mem_arb_pkg holds:
  - requester index constants: REQ_IF = 0, REQ_DM = 1, REQ_LD = 2
  - state encoding: IDLE = 2'd0, ACCESS = 2'd1, WAIT = 2'd2, RESP = 2'd3
- One sub-module, mem_arb_pick: combinational priority picker taking the req vector and the starve flag and producing a one-hot winner. The FSM, counters and latches stay in the top module.

## Test plan
- Lone fetch read, MEM_LAT = 2, if_addr = 0x40, memory returns 0x2002_0005 -> gnt[0] at t+1, done[0] and rdata = 0x2002_0005 at t+3, busy low at t+4.
- Data write dm_addr = 0x100, dm_wdata = 0xDEAD_BEEF -> mem_en = mem_we = 1 with that addr/data at t+1, done[1] at t+2, then a fetch of 0x100 returns 0xDEAD_BEEF.
- All three requests raised in the same cycle -> grant order loader, data, fetch, with exactly one done pulse per requester and an IDLE cycle between transactions.
- dm_req and if_req held continuously, STARVE_MAX = 4 -> 4 data grants, then 1 fetch grant, repeating; starve_cnt returns to 0 after each fetch grant.
- rst driven low during WAIT of a loader read -> all outputs 0 at once, no done[2]; after release, a pending if_req is granted normally.
- MEM_LAT = 1, back-to-back fetch reads -> no WAIT state; done two cycles after each req; mem_en high one cycle per transaction.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared constants and state encoding for the memory port arbiter
package mem_arb_pkg;

  localparam logic [1:0] REQ_IF = 2'd0;
  localparam logic [1:0] REQ_DM = 2'd1;
  localparam logic [1:0] REQ_LD = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-macro signals of the memory port arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic [2:0]        gnt;
  logic [2:0]        done;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
    input  ld_req, ld_we, ld_addr, ld_wdata, mem_rdata,
    output gnt, done, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
    output ld_req, ld_we, ld_addr, ld_wdata, mem_rdata,
    input  gnt, done, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_pick.sv
// rtl/mem_port_arbiter_pick.sv - combinational priority picker, loader > data > fetch with fetch anti-starvation
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [2:0] req_i,
  input  logic       starve_i,
  output logic [2:0] win_o
);

  always_comb begin
    win_o = '0;
    if (req_i[REQ_LD]) begin
      win_o[REQ_LD] = 1'b1;
    end else if (starve_i && req_i[REQ_IF]) begin
      win_o[REQ_IF] = 1'b1;
    end else if (req_i[REQ_DM]) begin
      win_o[REQ_DM] = 1'b1;
    end else if (req_i[REQ_IF]) begin
      win_o[REQ_IF] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one synchronous memory port between fetch, data and loader requesters
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.slave  bus
);

  arb_state_t        state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        starve_q, starve_d;
  logic [2:0]        wait_q, wait_d;
  logic [2:0]        win;
  logic              starve;

  assign starve = (starve_q == 4'(STARVE_MAX));

  mem_arb_pick u_pick (
    .req_i    ({bus.ld_req, bus.dm_req, bus.if_req}),
    .starve_i (starve),
    .win_o    (win)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      starve_q <= '0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      starve_q <= starve_d;
      wait_q   <= wait_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    starve_d = starve_q;
    wait_d   = wait_q;
    case (state_q)
      IDLE: begin
        if (win[REQ_LD]) begin
          state_d = ACCESS;
          owner_d = REQ_LD;
          we_d    = bus.ld_we;
          addr_d  = bus.ld_addr;
          wdata_d = bus.ld_wdata;
        end else if (win[REQ_DM]) begin
          state_d = ACCESS;
          owner_d = REQ_DM;
          we_d    = bus.dm_we;
          addr_d  = bus.dm_addr;
          wdata_d = bus.dm_wdata;
          // Only data grants that make a waiting fetch wait longer count toward starvation
          if (bus.if_req && !starve) starve_d = starve_q + 4'd1;
        end else if (win[REQ_IF]) begin
          state_d  = ACCESS;
          owner_d  = REQ_IF;
          we_d     = 1'b0;
          addr_d   = bus.if_addr;
          wdata_d  = '0;
          starve_d = '0;
        end
      end
      ACCESS: begin
        if (we_q || MEM_LAT <= 1) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
          wait_d  = 3'd1;
        end
      end
      WAIT: begin
        if (wait_q >= 3'(MEM_LAT - 1)) state_d = RESP;
        else wait_d = wait_q + 3'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.gnt       = (state_q == ACCESS) ? (3'b001 << owner_q) : 3'b000;
  assign bus.done      = (state_q == RESP) ? (3'b001 << owner_q) : 3'b000;
  assign bus.busy      = (state_q != IDLE);
  assign bus.mem_en    = (state_q == ACCESS);
  assign bus.mem_we    = (state_q == ACCESS) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.rdata     = (state_q == RESP && !we_q) ? bus.mem_rdata : '0;

endmodule
